// File: rtl/serial_adder.sv
// serial_adder: multi-cycle adder that sums a + b + cin, STEP bits per clock,
// keeping the inter-digit carry in a flop. A start/busy/done handshake
// sequences the operation. The LSB digit is processed first.
//
// Parameters:
//   WIDTH  operand/sum width (>= 1)
//   STEP   bits added per cycle (must divide WIDTH)
//
// Ports:
//   clk    rising-edge clock
//   rst_n  synchronous active-low reset
//   start  request, accepted in IDLE or DONE
//   a, b   operands, captured on an accepted start
//   cin    carry-in, captured on an accepted start
//   busy   high while digits are being processed
//   done   one-cycle pulse when sum/cout/ovf become valid
//   sum    low WIDTH bits of a + b + cin
//   cout   carry out of bit WIDTH-1
//   ovf    two's-complement overflow (carry into MSB xor carry out)
module serial_adder #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned STEP  = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);

  localparam int unsigned N     = WIDTH / STEP;
  localparam int unsigned CNT_W = (N > 1) ? $clog2(N) : 1;
  localparam int unsigned DW    = STEP + 1;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  // Elaboration-time parameter sanity.
  if (WIDTH < 1 || STEP < 1 || STEP > WIDTH || (WIDTH % STEP) != 0) begin : g_bad_params
    $error("serial_adder: STEP must divide WIDTH and satisfy 1 <= STEP <= WIDTH");
  end

  logic [1:0]       state;
  logic [1:0]       state_d;
  logic             busy_d;
  logic             done_d;
  logic             load;
  logic             advance;
  logic             last;

  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic             carry_q;
  logic [CNT_W-1:0] cnt;

  logic [DW-1:0]    dres;
  logic [STEP-1:0]  dsum;
  logic             dcarry;
  logic             msb_cin;

  assign last = (cnt == CNT_W'(N - 1));

  // One digit of the addition. Operand registers shift right, so the current
  // digit always sits in their low STEP bits.
  always_comb begin
    dres    = {1'b0, a_q[STEP-1:0]} + {1'b0, b_q[STEP-1:0]} + DW'(carry_q);
    dsum    = dres[STEP-1:0];
    dcarry  = dres[STEP];
    // Carry into the digit's top bit recovered from its sum and operand bits.
    msb_cin = dsum[STEP-1] ^ a_q[STEP-1] ^ b_q[STEP-1];
  end

  // Next-state and handshake decode.
  always_comb begin
    state_d = state;
    busy_d  = 1'b0;
    done_d  = 1'b0;
    load    = 1'b0;
    advance = 1'b0;
    case (state)
      ST_IDLE: begin
        if (start) begin
          load    = 1'b1;
          busy_d  = 1'b1;
          state_d = ST_RUN;
        end
      end
      ST_RUN: begin
        advance = 1'b1;
        if (last) begin
          done_d  = 1'b1;
          state_d = ST_DONE;
        end else begin
          busy_d  = 1'b1;
        end
      end
      ST_DONE: begin
        if (start) begin
          load    = 1'b1;
          busy_d  = 1'b1;
          state_d = ST_RUN;
        end else begin
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State, handshake outputs and datapath registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state   <= ST_IDLE;
      busy    <= 1'b0;
      done    <= 1'b0;
      a_q     <= '0;
      b_q     <= '0;
      carry_q <= 1'b0;
      cnt     <= '0;
      sum     <= '0;
      cout    <= 1'b0;
      ovf     <= 1'b0;
    end else begin
      state <= state_d;
      busy  <= busy_d;
      done  <= done_d;
      if (load) begin
        a_q     <= a;
        b_q     <= b;
        carry_q <= cin;
        cnt     <= '0;
      end else if (advance) begin
        a_q     <= a_q >> STEP;
        b_q     <= b_q >> STEP;
        carry_q <= dcarry;
        cnt     <= cnt + CNT_W'(1);
        // Result digits enter at the top; after N digits the first one has
        // reached bit 0.
        sum     <= (sum >> STEP) | (WIDTH'(dsum) << (WIDTH - STEP));
        if (last) begin
          cout <= dcarry;
          ovf  <= msb_cin ^ dcarry;
        end
      end
    end
  end

endmodule

// File: tb/tb_serial_adder.sv
// tb_serial_adder: directed self-checking bench for serial_adder in three
// configurations: 1/1 (full-adder truth table), 8/1 and 8/4.
module tb_serial_adder;

  logic clk;
  logic rst_n;

  logic start1, a1, b1, cin1;
  logic busy1, done1, sum1, cout1, ovf1;

  logic       start8, cin8;
  logic [7:0] a8, b8;
  logic       busy8, done8, cout8, ovf8;
  logic [7:0] sum8;

  logic       start4, cin4;
  logic [7:0] a4, b4;
  logic       busy4, done4, cout4, ovf4;
  logic [7:0] sum4;

  int checks;
  int errors;

  serial_adder #(.WIDTH(1), .STEP(1)) u1 (
    .clk(clk), .rst_n(rst_n), .start(start1), .a(a1), .b(b1), .cin(cin1),
    .busy(busy1), .done(done1), .sum(sum1), .cout(cout1), .ovf(ovf1)
  );

  serial_adder #(.WIDTH(8), .STEP(1)) u8 (
    .clk(clk), .rst_n(rst_n), .start(start8), .a(a8), .b(b8), .cin(cin8),
    .busy(busy8), .done(done8), .sum(sum8), .cout(cout8), .ovf(ovf8)
  );

  serial_adder #(.WIDTH(8), .STEP(4)) u4 (
    .clk(clk), .rst_n(rst_n), .start(start4), .a(a4), .b(b4), .cin(cin4),
    .busy(busy4), .done(done4), .sum(sum4), .cout(cout4), .ovf(ovf4)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    start1 = 0; a1 = 0; b1 = 0; cin1 = 0;
    start8 = 0; a8 = 0; b8 = 0; cin8 = 0;
    start4 = 0; a4 = 0; b4 = 0; cin4 = 0;
    repeat (3) tick();
    checks++;
    if ({busy8, done8, sum8, cout8, ovf8} !== 12'h000) begin
      errors++;
      $display("FAIL reset_u8: got busy=%b done=%b sum=%h cout=%b ovf=%b, all zero required",
               busy8, done8, sum8, cout8, ovf8);
    end
    checks++;
    if ({busy4, done4, sum4, cout4, ovf4} !== 12'h000) begin
      errors++;
      $display("FAIL reset_u4: got busy=%b done=%b sum=%h cout=%b ovf=%b, all zero required",
               busy4, done4, sum4, cout4, ovf4);
    end
    checks++;
    if ({busy1, done1, sum1, cout1, ovf1} !== 5'b0) begin
      errors++;
      $display("FAIL reset_u1: got %b, 00000 required", {busy1, done1, sum1, cout1, ovf1});
    end
    rst_n = 1'b1;
    tick();
  endtask

  // Full-adder truth table; index i = {a, b, cin}.
  task automatic test_full_adder();
    logic [1:0] exp_cs [8];
    logic       exp_ovf [8];
    logic [2:0] v;
    exp_cs  = '{2'd0, 2'd1, 2'd1, 2'd2, 2'd1, 2'd2, 2'd2, 2'd3};
    exp_ovf = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    for (int i = 0; i < 8; i++) begin
      v = 3'(i);
      a1 = v[2]; b1 = v[1]; cin1 = v[0];
      start1 = 1'b1;
      tick();
      start1 = 1'b0;
      checks++;
      if (busy1 !== 1'b1 || done1 !== 1'b0) begin
        errors++;
        $display("FAIL fa_run_%0d: busy=%b done=%b, busy=1 done=0 required", i, busy1, done1);
      end
      tick();
      checks++;
      if (done1 !== 1'b1 || {cout1, sum1} !== exp_cs[i] || ovf1 !== exp_ovf[i]) begin
        errors++;
        $display("FAIL fa_result_%0d: done=%b {cout,sum}=%b ovf=%b, done=1 %b ovf=%b required",
                 i, done1, {cout1, sum1}, ovf1, exp_cs[i], exp_ovf[i]);
      end
      tick();
    end
  endtask

  task automatic test_w8s1();
    logic [7:0] va [4];
    logic [7:0] vb [4];
    logic       vc [4];
    logic [7:0] es [4];
    logic       ec [4];
    logic       eo [4];
    int nbusy, lat;
    bit got;
    va = '{8'hFF, 8'h7F, 8'h80, 8'h3C};
    vb = '{8'h01, 8'h01, 8'h80, 8'h0F};
    vc = '{1'b0, 1'b0, 1'b0, 1'b1};
    es = '{8'h00, 8'h80, 8'h00, 8'h4C};
    ec = '{1'b1, 1'b0, 1'b1, 1'b0};
    eo = '{1'b0, 1'b1, 1'b1, 1'b0};
    for (int i = 0; i < 4; i++) begin
      a8 = va[i]; b8 = vb[i]; cin8 = vc[i];
      start8 = 1'b1;
      tick();
      start8 = 1'b0;
      a8 = 8'h00; b8 = 8'h00; cin8 = 1'b0;
      nbusy = 0; lat = 0; got = 0;
      for (int e = 1; e <= 20 && !got; e++) begin
        if (e > 1) tick();
        if (busy8) nbusy++;
        if (done8) begin
          got = 1;
          lat = e;
        end
      end
      checks++;
      if (!got || lat != 9 || nbusy != 8) begin
        errors++;
        $display("FAIL w8s1_timing_%0d: done_seen=%0d latency=%0d busy_cycles=%0d, 1/9/8 required",
                 i, got, lat, nbusy);
      end
      checks++;
      if (sum8 !== es[i] || cout8 !== ec[i] || ovf8 !== eo[i]) begin
        errors++;
        $display("FAIL w8s1_result_%0d: sum=%h cout=%b ovf=%b, sum=%h cout=%b ovf=%b required",
                 i, sum8, cout8, ovf8, es[i], ec[i], eo[i]);
      end
      tick();
      checks++;
      if (done8 !== 1'b0 || busy8 !== 1'b0 || sum8 !== es[i] || cout8 !== ec[i]) begin
        errors++;
        $display("FAIL w8s1_hold_%0d: done=%b busy=%b sum=%h cout=%b, 0/0/%h/%b required",
                 i, done8, busy8, sum8, cout8, es[i], ec[i]);
      end
    end
  endtask

  task automatic test_back_to_back();
    // A5 + 5A + 1 = 0x100.
    a4 = 8'hA5; b4 = 8'h5A; cin4 = 1'b1;
    start4 = 1'b1;
    tick();
    start4 = 1'b0;
    checks++;
    if (busy4 !== 1'b1 || done4 !== 1'b0) begin
      errors++;
      $display("FAIL w8s4_busy1: busy=%b done=%b, 1/0 required", busy4, done4);
    end
    tick();
    checks++;
    if (busy4 !== 1'b1 || done4 !== 1'b0) begin
      errors++;
      $display("FAIL w8s4_busy2: busy=%b done=%b, 1/0 required", busy4, done4);
    end
    tick();
    checks++;
    if (done4 !== 1'b1 || busy4 !== 1'b0 || sum4 !== 8'h00 || cout4 !== 1'b1 || ovf4 !== 1'b0) begin
      errors++;
      $display("FAIL w8s4_result: done=%b busy=%b sum=%h cout=%b ovf=%b, 1/0/00/1/0 required",
               done4, busy4, sum4, cout4, ovf4);
    end
    // Second start presented in the DONE cycle.
    a4 = 8'h12; b4 = 8'h34; cin4 = 1'b0;
    start4 = 1'b1;
    tick();
    start4 = 1'b0;
    checks++;
    if (busy4 !== 1'b1 || done4 !== 1'b0) begin
      errors++;
      $display("FAIL b2b_busy: busy=%b done=%b, 1/0 required", busy4, done4);
    end
    repeat (2) tick();
    checks++;
    if (done4 !== 1'b1 || sum4 !== 8'h46 || cout4 !== 1'b0 || ovf4 !== 1'b0) begin
      errors++;
      $display("FAIL b2b_result: done=%b sum=%h cout=%b ovf=%b, 1/46/0/0 required",
               done4, sum4, cout4, ovf4);
    end
    tick();
  endtask

  // start held high from IDLE: one result every 3 cycles, no idle gaps.
  task automatic test_continuous();
    int ndone, nidle;
    a4 = 8'h01; b4 = 8'h02; cin4 = 1'b0;
    start4 = 1'b1;
    ndone = 0; nidle = 0;
    for (int e = 0; e < 9; e++) begin
      tick();
      if (done4) ndone++;
      if (!busy4 && !done4) nidle++;
    end
    start4 = 1'b0;
    checks++;
    if (ndone != 3 || nidle != 0 || sum4 !== 8'h03) begin
      errors++;
      $display("FAIL continuous: done_pulses=%0d idle_cycles=%0d sum=%h, 3/0/03 required",
               ndone, nidle, sum4);
    end
    repeat (2) tick();
  endtask

  task automatic test_start_ignored();
    int lat;
    bit got;
    a8 = 8'h10; b8 = 8'h20; cin8 = 1'b0;
    start8 = 1'b1;
    tick();
    start8 = 1'b0;
    got = 0; lat = 0;
    for (int e = 1; e <= 20 && !got; e++) begin
      if (e > 1) tick();
      // Competing request with different operands mid-operation.
      if (e == 3) begin
        a8 = 8'hFF; b8 = 8'hFF; cin8 = 1'b1; start8 = 1'b1;
      end else begin
        start8 = 1'b0;
      end
      if (done8) begin
        got = 1;
        lat = e;
      end
    end
    start8 = 1'b0;
    checks++;
    if (!got || lat != 9 || sum8 !== 8'h30 || cout8 !== 1'b0 || ovf8 !== 1'b0) begin
      errors++;
      $display("FAIL start_ignored: done_seen=%0d latency=%0d sum=%h cout=%b ovf=%b, 1/9/30/0/0 required",
               got, lat, sum8, cout8, ovf8);
    end
    tick();
  endtask

  task automatic test_reset_mid_run();
    int ndone, lat;
    bit got;
    a8 = 8'hC3; b8 = 8'h3C; cin8 = 1'b0;
    start8 = 1'b1;
    tick();
    start8 = 1'b0;
    repeat (3) tick();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    checks++;
    if ({busy8, done8, sum8, cout8, ovf8} !== 12'h000) begin
      errors++;
      $display("FAIL midrun_reset: busy=%b done=%b sum=%h cout=%b ovf=%b, all zero required",
               busy8, done8, sum8, cout8, ovf8);
    end
    ndone = 0;
    for (int e = 0; e < 12; e++) begin
      tick();
      if (done8 || busy8) ndone++;
    end
    checks++;
    if (ndone != 0) begin
      errors++;
      $display("FAIL midrun_no_done: activity_cycles=%0d, 0 required", ndone);
    end
    // Fresh operation after reset: 55 + 22 + 1 = 78.
    a8 = 8'h55; b8 = 8'h22; cin8 = 1'b1;
    start8 = 1'b1;
    tick();
    start8 = 1'b0;
    got = 0; lat = 0;
    for (int e = 1; e <= 20 && !got; e++) begin
      if (e > 1) tick();
      if (done8) begin
        got = 1;
        lat = e;
      end
    end
    checks++;
    if (!got || lat != 9 || sum8 !== 8'h78 || cout8 !== 1'b0 || ovf8 !== 1'b0) begin
      errors++;
      $display("FAIL post_reset_op: done_seen=%0d latency=%0d sum=%h cout=%b ovf=%b, 1/9/78/0/0 required",
               got, lat, sum8, cout8, ovf8);
    end
    tick();
  endtask

  initial begin
    checks = 0;
    errors = 0;
    test_reset();
    test_full_adder();
    test_w8s1();
    test_back_to_back();
    test_continuous();
    test_start_ignored();
    test_reset_mid_run();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/serial_adder.md
# serial_adder

Parametrised multi-cycle adder. It adds two WIDTH-bit operands plus a carry-in, STEP bits per clock, and holds the carry between digits in a flop. It is the sequential successor to the single-bit full adder: a start/busy/done handshake replaces purely combinational evaluation. Intended as a small-area arithmetic unit for control datapaths, and as the base for later serial multiply/accumulate blocks.

## Interface
Parameters:
- WIDTH, 8, operand and sum width in bits; must be ≥1.
- STEP, 1, bits added per cycle; must divide WIDTH exactly (1 ≤ STEP ≤ WIDTH).

Ports:
- clk  input  1  single clock, all state updates on rising edge.
- rst_n  input  1  reset, synchronous, active-low.
- start  input  1  request; sampled only when not busy.
- a  input  WIDTH  operand A, captured on accepted start.
- b  input  WIDTH  operand B, captured on accepted start.
- cin  input  1  carry-in, captured on accepted start.
- busy  output  1  high while digits are being processed.
- done  output  1  one-cycle pulse when the result becomes valid.
- sum  output  WIDTH  result a+b+cin, low WIDTH bits.
- cout  output  1  carry out of bit WIDTH-1.
- ovf  output  1  two's-complement overflow: carry into MSB XOR carry out of MSB.

## Operation
- N = WIDTH/STEP digits; digit i covers bits [i*STEP +: STEP], LSB digit first.
- States: IDLE, RUN, DONE.
  - IDLE: busy=0, done=0. start=1 → capture a, b, cin into internal registers; clear digit counter; → RUN.
  - RUN: busy=1. Each edge adds digit i of A and B plus the carry register, writes STEP result bits into sum, updates carry, and increments the counter. Last digit (i=N-1) → DONE.
  - DONE: done=1 for exactly this cycle; busy=0. start=1 → capture and → RUN (back-to-back). Otherwise → IDLE.
- start is ignored in RUN. Operand inputs may change freely after capture.
- sum, cout and ovf are valid from the DONE cycle. They hold unchanged through IDLE until the next accepted start.
- After an accepted start, sum/cout/ovf may change during RUN. They are not valid until done.
- The carry register never carries into the next operation: each accepted start reloads it from cin.
- Arithmetic is unsigned modulo 2^WIDTH. {cout,sum} equals a+b+cin exactly. ovf is computed from carry into bit WIDTH-1 and cout.

## Timing
- Reset (rst_n=0 at an edge) → IDLE; busy=0, done=0, sum=0, cout=0, ovf=0; counter and carry cleared. Reset applies in any state, including mid-RUN. The operation is abandoned and no done is produced.
- Start accepted at edge k:
  - busy=1 after edges k … k+N-1 (N cycles).
  - done=1 after edge k+N (one cycle).
  - Latency from start edge to done = N+1 edges.
- Back-to-back: start held high in the DONE cycle → busy rises after that edge. Throughput is one result per N+1 cycles.
- start=1 continuously from IDLE → new operation each N+1 cycles, with no IDLE cycle in between.
- WIDTH=STEP (N=1): RUN lasts one cycle, then done.
- rst_n has priority over start on the same edge.

## Test plan
- WIDTH=1, STEP=1, all 8 combinations of a, b, cin, each with start pulse:
  - {cout,sum} = a+b+cin.
  - done 2 edges after start.
  - This reproduces the full-adder truth table.
- WIDTH=8, STEP=1, start with a=0xFF, b=0x01, cin=0:
  - busy high 8 cycles.
  - done on the 9th edge.
  - sum=0x00, cout=1, ovf=0.
- WIDTH=8, STEP=1, a=0x7F, b=0x01, cin=0 → sum=0x80, cout=0, ovf=1. Then a=0x80, b=0x80, cin=0 → sum=0x00, cout=1, ovf=1.
- WIDTH=8, STEP=4, a=0xA5, b=0x5A, cin=1:
  - busy 2 cycles, done on 3rd edge.
  - sum=0x00, cout=1, ovf=0.
  - Second start held in the DONE cycle with a=0x12, b=0x34, cin=0 → sum=0x46 after a further 3 edges.
- Control hazards:
  - Pulse start with different operands during RUN → ignored; original result delivered on schedule.
  - Assert rst_n=0 at edge 4 of an 8-cycle operation → all outputs 0 next cycle, no done pulse.
  - A fresh start after reset completes normally.
